// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 raster timing constants and text-grid geometry.
package vga_timing_pkg;

    localparam int POS_W = 10;

    localparam int H_DISPLAY_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;
    localparam int V_DISPLAY_DEF = 480;
    localparam int V_BOTTOM_DEF  = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_TOP_DEF     = 33;

    localparam int H_TOTAL = H_DISPLAY_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
    localparam int V_TOTAL = V_DISPLAY_DEF + V_BOTTOM_DEF + V_SYNC_DEF + V_TOP_DEF;

    localparam int HSYNC_START = H_DISPLAY_DEF + H_FRONT_DEF;
    localparam int HSYNC_END   = HSYNC_START + H_SYNC_DEF - 1;
    localparam int VSYNC_START = V_DISPLAY_DEF + V_BOTTOM_DEF;
    localparam int VSYNC_END   = VSYNC_START + V_SYNC_DEF - 1;

    localparam int TEXT_COLS = 80;
    localparam int TEXT_ROWS = 30;
    localparam int CELL_W    = 8;
    localparam int CELL_H    = 16;

    // Converts an active-high window decode into the pin level.
    function automatic logic sync_level(input logic active, input bit active_low);
        return active ^ active_low;
    endfunction

endpackage

// File: rtl/vga_sync_core_if.sv
// Raster timing outputs of vga_sync_core as seen by the text pipeline.
interface vga_sync_core_if;
    import vga_timing_pkg::*;

    logic             pix_tick;
    logic             hsync;
    logic             vsync;
    logic             display_on;
    logic [POS_W-1:0] hpos;
    logic [POS_W-1:0] vpos;
    logic [6:0]       text_col;
    logic [4:0]       text_row;
    logic [2:0]       xofs;
    logic [3:0]       yofs;
    logic             line_end;
    logic             frame_end;

    modport master (
        output pix_tick, hsync, vsync, display_on, hpos, vpos,
               text_col, text_row, xofs, yofs, line_end, frame_end
    );

    modport slave (
        input pix_tick, hsync, vsync, display_on, hpos, vpos,
              text_col, text_row, xofs, yofs, line_end, frame_end
    );

endinterface

// File: rtl/pixel_prescaler.sv
// Free-running 2^N divider; tick is high for the one clk where the count is all ones.
module pixel_prescaler #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    logic [N-1:0] cnt_q;
    logic [N-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = &cnt_q;

endmodule

// File: rtl/vga_sync_core.sv
// Horizontal/vertical raster counters with sync, display-enable and text-cell decode.
module vga_sync_core
    import vga_timing_pkg::*;
#(
    parameter int PRESCALE_N      = 2,
    parameter int H_DISPLAY       = H_DISPLAY_DEF,
    parameter int H_FRONT         = H_FRONT_DEF,
    parameter int H_SYNC          = H_SYNC_DEF,
    parameter int H_BACK          = H_BACK_DEF,
    parameter int V_DISPLAY       = V_DISPLAY_DEF,
    parameter int V_BOTTOM        = V_BOTTOM_DEF,
    parameter int V_SYNC          = V_SYNC_DEF,
    parameter int V_TOP           = V_TOP_DEF,
    parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    vga_sync_core_if.master  vga
);

    localparam logic [POS_W-1:0] H_LAST   = POS_W'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [POS_W-1:0] V_LAST   = POS_W'(V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP - 1);
    localparam logic [POS_W-1:0] H_VIS    = POS_W'(H_DISPLAY);
    localparam logic [POS_W-1:0] V_VIS    = POS_W'(V_DISPLAY);
    localparam logic [POS_W-1:0] HS_FIRST = POS_W'(H_DISPLAY + H_FRONT);
    localparam logic [POS_W-1:0] HS_LAST  = POS_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [POS_W-1:0] VS_FIRST = POS_W'(V_DISPLAY + V_BOTTOM);
    localparam logic [POS_W-1:0] VS_LAST  = POS_W'(V_DISPLAY + V_BOTTOM + V_SYNC - 1);

    logic             pix_tick;
    logic [POS_W-1:0] hpos_q, hpos_d;
    logic [POS_W-1:0] vpos_q, vpos_d;
    logic             h_last;
    logic             v_last;
    logic             hs_act;
    logic             vs_act;

    pixel_prescaler #(
        .N (PRESCALE_N)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .tick  (pix_tick)
    );

    assign h_last = (hpos_q == H_LAST);
    assign v_last = (vpos_q == V_LAST);

    // vpos steps on the same edge that wraps hpos.
    always_comb begin
        hpos_d = hpos_q;
        vpos_d = vpos_q;
        if (pix_tick) begin
            if (h_last) begin
                hpos_d = '0;
                vpos_d = v_last ? '0 : vpos_q + 1'b1;
            end else begin
                hpos_d = hpos_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hpos_q <= '0;
            vpos_q <= '0;
        end else begin
            hpos_q <= hpos_d;
            vpos_q <= vpos_d;
        end
    end

    assign hs_act = (hpos_q >= HS_FIRST) && (hpos_q <= HS_LAST);
    assign vs_act = (vpos_q >= VS_FIRST) && (vpos_q <= VS_LAST);

    assign vga.pix_tick   = pix_tick;
    assign vga.hsync      = sync_level(hs_act, SYNC_ACTIVE_LOW);
    assign vga.vsync      = sync_level(vs_act, SYNC_ACTIVE_LOW);
    assign vga.display_on = (hpos_q < H_VIS) && (vpos_q < V_VIS);
    assign vga.hpos       = hpos_q;
    assign vga.vpos       = vpos_q;
    // Cell fields are raw bit slices; outside the visible area they are meaningless.
    assign vga.text_col   = hpos_q[9:3];
    assign vga.text_row   = vpos_q[8:4];
    assign vga.xofs       = hpos_q[2:0];
    assign vga.yofs       = vpos_q[3:0];
    assign vga.line_end   = pix_tick & h_last;
    assign vga.frame_end  = pix_tick & h_last & v_last;

endmodule

// File: tb/tb_vga_sync_core.sv
// Bench for vga_sync_core: default-timing instance plus a short-line instance for full frames.
module tb_vga_sync_core;

    typedef struct packed {
        logic       pix;
        logic       hs;
        logic       vs;
        logic       de;
        logic       le;
        logic       fe;
        logic [9:0] hpos;
        logic [9:0] vpos;
        logic [6:0] tcol;
        logic [4:0] trow;
        logic [2:0] xofs;
        logic [3:0] yofs;
    } out_t;

    typedef struct {
        int         c;
        logic [9:0] hpos;
        logic [9:0] vpos;
        logic       pix;
        logic       hs;
        logic       de;
        logic       le;
        logic [6:0] tcol;
        logic [2:0] xofs;
    } vec_t;

    logic clk;
    logic rst_a;
    logic rst_b;
    int   c_a;
    int   c_b;
    int   n_checks;
    int   n_err;
    bit   run_chk;

    vga_sync_core_if if_a ();
    vga_sync_core_if if_b ();

    vga_sync_core dut_a (
        .clk   (clk),
        .reset (rst_a),
        .vga   (if_a)
    );

    vga_sync_core #(
        .PRESCALE_N (1),
        .H_DISPLAY  (8),
        .H_FRONT    (1),
        .H_SYNC     (1),
        .H_BACK     (1)
    ) dut_b (
        .clk   (clk),
        .reset (rst_b),
        .vga   (if_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edges seen since the last reset release.
    always @(posedge clk or negedge rst_a) begin
        if (!rst_a) c_a <= 0;
        else        c_a <= c_a + 1;
    end
    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) c_b <= 0;
        else        c_b <= c_b + 1;
    end

    out_t obs_a, obs_b;
    assign obs_a = {if_a.pix_tick, if_a.hsync, if_a.vsync, if_a.display_on, if_a.line_end,
                    if_a.frame_end, if_a.hpos, if_a.vpos, if_a.text_col, if_a.text_row,
                    if_a.xofs, if_a.yofs};
    assign obs_b = {if_b.pix_tick, if_b.hsync, if_b.vsync, if_b.display_on, if_b.line_end,
                    if_b.frame_end, if_b.hpos, if_b.vpos, if_b.text_col, if_b.text_row,
                    if_b.xofs, if_b.yofs};

    // Reference: position is the number of whole pixel periods elapsed since release.
    function automatic out_t model(input int c, input int n, input int hd, input int hf,
                                   input int hsw, input int hb, input int vd, input int vb,
                                   input int vsw, input int vt);
        out_t r;
        int ht, ticks, h, v;
        ht    = hd + hf + hsw + hb;
        ticks = c / (1 << n);
        h     = ticks % ht;
        v     = (ticks / ht) % (vd + vb + vsw + vt);
        r.pix  = ((c % (1 << n)) == (1 << n) - 1);
        r.hs   = !((h >= hd + hf) && (h < hd + hf + hsw));
        r.vs   = !((v >= vd + vb) && (v < vd + vb + vsw));
        r.de   = (h < hd) && (v < vd);
        r.le   = r.pix && (h == ht - 1);
        r.fe   = r.le && (v == vd + vb + vsw + vt - 1);
        r.hpos = 10'(h);
        r.vpos = 10'(v);
        r.tcol = 7'((h / 8) % 128);
        r.trow = 5'((v / 16) % 32);
        r.xofs = 3'(h % 8);
        r.yofs = 4'(v % 16);
        return r;
    endfunction

    function automatic out_t model_a(input int c);
        return model(c, 2, 640, 16, 96, 48, 480, 10, 2, 33);
    endfunction

    function automatic out_t model_b(input int c);
        return model(c, 1, 8, 1, 1, 1, 480, 10, 2, 33);
    endfunction

    task automatic check(input string name, input out_t got, input out_t exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h (hpos %0d exp %0d, vpos %0d exp %0d)",
                     name, got, exp, got.hpos, exp.hpos, got.vpos, exp.vpos);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (run_chk) begin
            check("model_a", obs_a, model_a(c_a));
            check("model_b", obs_b, model_b(c_b));
        end
    end

    vec_t vecs[12];

    initial begin
        int   le_cnt, hs_low, de_fall_h, fe_cnt, vs_ticks, n;
        bit   prev_de, prev_fe, hit;

        vecs[0]  = '{0,    10'd0,   10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 7'd0,  3'd0};
        vecs[1]  = '{3,    10'd0,   10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 7'd0,  3'd0};
        vecs[2]  = '{4,    10'd1,   10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 7'd0,  3'd1};
        vecs[3]  = '{2548, 10'd637, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 7'd79, 3'd5};
        vecs[4]  = '{2559, 10'd639, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 7'd79, 3'd7};
        vecs[5]  = '{2560, 10'd640, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0, 7'd80, 3'd0};
        vecs[6]  = '{2623, 10'd655, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 7'd81, 3'd7};
        vecs[7]  = '{2624, 10'd656, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd82, 3'd0};
        vecs[8]  = '{3007, 10'd751, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0, 7'd93, 3'd7};
        vecs[9]  = '{3008, 10'd752, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0, 7'd94, 3'd0};
        vecs[10] = '{3199, 10'd799, 10'd0, 1'b1, 1'b1, 1'b0, 1'b1, 7'd99, 3'd7};
        vecs[11] = '{3200, 10'd0,   10'd1, 1'b0, 1'b1, 1'b1, 1'b0, 7'd0,  3'd0};

        n_checks = 0;
        n_err    = 0;
        run_chk  = 1'b0;
        rst_a    = 1'b0;
        rst_b    = 1'b0;

        repeat (5) @(negedge clk);
        check("reset_a", obs_a, '{pix: 1'b0, hs: 1'b1, vs: 1'b1, de: 1'b1, le: 1'b0,
                                  fe: 1'b0, default: '0});
        check("reset_b", obs_b, model_b(0));
        rst_a   = 1'b1;
        rst_b   = 1'b1;
        run_chk = 1'b1;

        // First line of the default-timing instance, walked through the vector table.
        le_cnt = 0; hs_low = 0; de_fall_h = -1; prev_de = 1'b1;
        foreach (vecs[i]) begin
            while (c_a < vecs[i].c) begin
                @(negedge clk);
                if (if_a.line_end) le_cnt++;
                if (!if_a.hsync) hs_low++;
                if (prev_de && !if_a.display_on && de_fall_h < 0) de_fall_h = int'(if_a.hpos);
                prev_de = if_a.display_on;
            end
            check_int($sformatf("vec%0d_hpos", i), int'(if_a.hpos), int'(vecs[i].hpos));
            check("vec_fields", {if_a.pix_tick, if_a.hsync, if_a.display_on, if_a.line_end,
                                 if_a.vpos, if_a.text_col, if_a.xofs, 14'd0, 1'b0},
                  {vecs[i].pix, vecs[i].hs, vecs[i].de, vecs[i].le, vecs[i].vpos,
                   vecs[i].tcol, vecs[i].xofs, 14'd0, 1'b0});
        end
        check_int("line_end_count", le_cnt, 1);
        check_int("hsync_low_clk", hs_low, 384);
        check_int("de_fall_hpos", de_fall_h, 640);

        // Full frame on the short-line instance (default vertical timing).
        fe_cnt = 0; vs_ticks = 0; prev_fe = 1'b0;
        while (c_b < 11560) begin
            @(negedge clk);
            if (if_b.frame_end) begin
                fe_cnt++;
                check_int("fe_vpos", int'(if_b.vpos), 524);
            end
            if (prev_fe) begin
                check_int("wrap_vpos", int'(if_b.vpos), 0);
                check_int("wrap_hpos", int'(if_b.hpos), 0);
            end
            prev_fe = if_b.frame_end;
            if (if_b.pix_tick && !if_b.vsync) vs_ticks++;
            if (c_b == 10406) begin
                check_int("vpos473", int'(if_b.vpos), 473);
                check_int("text_row473", int'(if_b.text_row), 29);
                check_int("yofs473", int'(if_b.yofs), 9);
            end
        end
        check_int("frame_end_count", fe_cnt, 1);
        check_int("vsync_low_ticks", vs_ticks, 22);

        // Mid-line reset at hpos 300, then prescaler restart.
        hit = 1'b0;
        for (int k = 0; k < 3300 && !hit; k++) begin
            @(negedge clk);
            hit = (if_a.hpos == 10'd300);
        end
        check_int("reach_hpos300", int'(hit), 1);
        #2 rst_a = 1'b0;
        #1 check("midreset_a", obs_a, model_a(0));
        repeat (2) @(negedge clk);
        rst_a = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!if_a.pix_tick && n < 8);
        check_int("restart_tick_clk", n, 3);
        @(negedge clk);
        check_int("restart_hpos", int'(if_a.hpos), 1);

        // Mid-frame reset at vpos 200.
        hit = 1'b0;
        for (int k = 0; k < 12000 && !hit; k++) begin
            @(negedge clk);
            hit = (if_b.vpos == 10'd200);
        end
        check_int("reach_vpos200", int'(hit), 1);
        #2 rst_b = 1'b0;
        #1 check("midreset_b", obs_b, model_b(0));
        @(negedge clk);
        rst_b = 1'b1;

        // Random reset pulses on either instance; the model checker runs throughout.
        for (int i = 0; i < 8; i++) begin
            bit sel;
            sel = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 3000)) @(negedge clk);
            #2;
            if (sel) rst_a = 1'b0;
            else     rst_b = 1'b0;
            #1;
            if (sel) check("rand_reset_a", obs_a, model_a(0));
            else     check("rand_reset_b", obs_b, model_b(0));
            repeat ($urandom_range(1, 4)) @(negedge clk);
            rst_a = 1'b1;
            rst_b = 1'b1;
        end

        repeat (200) @(negedge clk);
        run_chk = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
